// File: rtl/ntt_pkg.sv
// Shared constants, unload FSM states, beat payload and lane-slice helper for the NTT result path.
package ntt_pkg;

    localparam int unsigned DATA_WIDTH   = 12;
    localparam int unsigned LANES        = 16;
    localparam int unsigned OUTPUT_WIDTH = LANES * DATA_WIDTH;
    localparam int unsigned Q            = 3329;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } unload_state_t;

    typedef struct packed {
        logic                    last;
        logic [OUTPUT_WIDTH-1:0] data;
    } unload_beat_t;

    // Lane j sits at [DATA_WIDTH*j +: DATA_WIDTH]; lanes 0..7 are A ports, 8..15 are B ports.
    function automatic logic [DATA_WIDTH-1:0] lane_slice(input logic [OUTPUT_WIDTH-1:0] row,
                                                         input int unsigned             j);
        return row[j*DATA_WIDTH +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/ntt_sync_fifo.sv
// Show-ahead synchronous FIFO; entry 0 is the head register, so the output is purely registered.
module ntt_sync_fifo #(
    parameter  int unsigned WIDTH = 193,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem     [DEPTH];
    logic [WIDTH-1:0] w_mem_nxt [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_wr_idx;
    logic             r_valid;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    // Pop shifts every entry toward the head; the push lands just behind the surviving entries.
    always_comb begin
        w_wr_idx    = w_pop ? (r_count - CW'(1)) : r_count;
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_mem_nxt[i] = r_mem[i];
        end
        if (w_pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                w_mem_nxt[i] = r_mem[i+1];
            end
            w_mem_nxt[DEPTH-1] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_push && (CW'(i) == w_wr_idx)) begin
                w_mem_nxt[i] = i_din;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_valid <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
        end
    end

    assign o_dout  = r_mem[0];
    assign o_valid = r_valid;
    assign o_count = r_count;

endmodule

// File: rtl/ntt_result_unloader.sv
// Walks every BRAM row after a transform and streams each 16-lane row as one valid/ready beat.
// Optional NTT_UNLOAD_REDUCE_EN adds a registered final mod-Q subtraction per lane before the FIFO.
module ntt_result_unloader
    import ntt_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned READ_LATE  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_unload,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [OUTPUT_WIDTH-1:0] data_bram_i,
    output logic [OUTPUT_WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic                    busy,
    output logic                    done_unload
);

`ifdef NTT_UNLOAD_REDUCE_EN
    localparam int unsigned RED_STAGES = 1;
`else
    localparam int unsigned RED_STAGES = 0;
`endif
    localparam int unsigned LAT      = READ_LATE + RED_STAGES;
    localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ROW_LAST = (1 << ADDR_WIDTH) - 1;

    unload_state_t         r_state;
    logic [ADDR_WIDTH-1:0] r_row;
    logic [LAT-1:0]        r_vld_pipe;
    logic [LAT-1:0]        r_last_pipe;
    logic [CW-1:0]         r_inflight;
    logic [CW-1:0]         w_fifo_count;
    logic [CW:0]           w_total;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_valid;
    unload_beat_t          w_fifo_din;
    unload_beat_t          w_fifo_dout;

    // Credit counts buffered beats plus reads still in flight; a same-cycle pop is not credited.
    assign w_total  = (CW+1)'(w_fifo_count) + (CW+1)'(r_inflight);
    assign w_credit = w_total < (CW+1)'(FIFO_DEPTH);
    assign w_issue  = ((r_state == IDLE) && start_unload) || ((r_state == READ) && w_credit);
    assign w_push   = r_vld_pipe[LAT-1];
    assign w_pop    = w_fifo_valid && dout_ready;

`ifdef NTT_UNLOAD_REDUCE_EN
    logic [OUTPUT_WIDTH-1:0] r_red_data;
    logic [OUTPUT_WIDTH-1:0] w_red_data;

    always_comb begin
        w_red_data = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            w_red_data[j*DATA_WIDTH +: DATA_WIDTH] =
                (lane_slice(data_bram_i, j) >= DATA_WIDTH'(Q)) ?
                (lane_slice(data_bram_i, j) - DATA_WIDTH'(Q)) : lane_slice(data_bram_i, j);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_red_data <= '0;
        end else if (r_vld_pipe[READ_LATE-1]) begin
            r_red_data <= w_red_data;
        end
    end

    assign w_fifo_din.data = r_red_data;
`else
    assign w_fifo_din.data = data_bram_i;
`endif
    assign w_fifo_din.last = r_last_pipe[LAT-1];

    // Control FSM, read issue and in-flight read tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_row       <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            done_unload <= 1'b0;
            r_inflight  <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            rd_en          <= w_issue;
            done_unload    <= 1'b0;
            r_inflight     <= r_inflight + CW'(w_issue) - CW'(w_push);
            r_vld_pipe[0]  <= rd_en;
            r_last_pipe[0] <= rd_en && (rd_addr == ADDR_WIDTH'(ROW_LAST));
            for (int unsigned i = 1; i < LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
            case (r_state)
                IDLE: begin
                    if (start_unload) begin
                        r_state <= READ;
                        busy    <= 1'b1;
                        rd_addr <= '0;
                        r_row   <= ADDR_WIDTH'(1);
                    end
                end
                READ: begin
                    if (w_credit) begin
                        rd_addr <= r_row;
                        if (r_row == ADDR_WIDTH'(ROW_LAST)) begin
                            r_state <= DRAIN;
                        end else begin
                            r_row <= r_row + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_fifo_dout.last) begin
                        r_state     <= DONE;
                        busy        <= 1'b0;
                        done_unload <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ntt_sync_fifo #(
        .WIDTH ($bits(unload_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign dout       = w_fifo_dout.data;
    assign dout_last  = w_fifo_dout.last;
    assign dout_valid = w_fifo_valid;

endmodule

// File: tb/tb_ntt_result_unloader.sv
// Directed bench for ntt_result_unloader with a 1-cycle BRAM model preloaded with row r, lane j = 16r+j.
module tb_ntt_result_unloader;
    import ntt_pkg::*;

    localparam int ROWS  = 32;
    localparam int DEPTH = 4;
`ifdef NTT_UNLOAD_REDUCE_EN
    localparam int EXP_FIRST = 4;
`else
    localparam int EXP_FIRST = 3;
`endif

    logic         clk;
    logic         rst_i;
    logic         start_unload;
    logic         rd_en;
    logic [4:0]   rd_addr;
    logic [191:0] data_bram_i;
    logic [191:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         busy;
    logic         done_unload;

    logic [191:0] mem [ROWS];
    logic [191:0] bram_q;
    logic         pat [4];
    bit           lane_check;
    int           n_checks;
    int           n_errors;

    ntt_result_unloader dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_unload (start_unload),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .data_bram_i  (data_bram_i),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_last    (dout_last),
        .busy         (busy),
        .done_unload  (done_unload)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) bram_q <= mem[rd_addr];
    end
    assign data_bram_i = bram_q;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] exp_row(input int r);
        logic [191:0] v;
        logic [11:0]  c;
        v = '0;
        for (int j = 0; j < 16; j++) begin
            c = lane_slice(mem[r], j);
`ifdef NTT_UNLOAD_REDUCE_EN
            if (c >= 12'd3329) c = c - 12'd3329;
`endif
            v[j*12 +: 12] = c;
        end
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rd_en"}, 192'(rd_en), 192'(0));
        check_eq({tag, "_rd_addr"}, 192'(rd_addr), 192'(0));
        check_eq({tag, "_dout"}, dout, 192'(0));
        check_eq({tag, "_valid"}, 192'(dout_valid), 192'(0));
        check_eq({tag, "_last"}, 192'(dout_last), 192'(0));
        check_eq({tag, "_busy"}, 192'(busy), 192'(0));
        check_eq({tag, "_done"}, 192'(done_unload), 192'(0));
    endtask

    // mode 0: ready high, 1: random 1,0,0,1 ready, 2: ready low 20 cycles, 3: extra start, 4: reset at beat 12
    task automatic run_unload(input int mode);
        int           cyc, beats, reads, done_cnt, done_cyc, last_cyc, first_valid;
        logic         prev_stall;
        logic [191:0] prev_dout;
        logic         prev_last;
        logic [191:0] row_v;
        beats = 0; reads = 0; done_cnt = 0; done_cyc = 0; last_cyc = -10; first_valid = -1;
        prev_stall = 1'b0; prev_dout = '0; prev_last = 1'b0;
        start_unload = 1'b1;
        dout_ready   = (mode != 2);
        @(negedge clk);
        start_unload = 1'b0;
        cyc = 1;
        check_eq("rd_en_cycle1", 192'(rd_en), 192'(1));
        while (1) begin
            case (mode)
                1:       dout_ready = pat[$urandom_range(0, 3)];
                2:       dout_ready = (cyc > 20);
                default: dout_ready = 1'b1;
            endcase
            start_unload = (mode == 3) && (cyc == 10);
            if (prev_stall) begin
                check_eq("stall_dout", dout, prev_dout);
                check_eq("stall_valid", 192'(dout_valid), 192'(1));
                check_eq("stall_last", 192'(dout_last), 192'(prev_last));
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
            if (rd_en) begin
                check_eq("rd_addr", 192'(rd_addr), 192'(reads));
                reads++;
            end
            check_eq("occupancy", 192'((reads - beats) <= DEPTH), 192'(1));
            if (dout_valid && first_valid < 0) first_valid = cyc;
            if (mode == 2 && cyc == 20) check_eq("stall_reads", 192'(reads), 192'(4));
            if (done_unload) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("done_timing", 192'(cyc), 192'(last_cyc + 1));
            end
            check_eq("busy", 192'(busy), 192'(done_cnt == 0));
            if (dout_valid && dout_ready) begin
                check_eq("beat_data", dout, exp_row(beats));
                check_eq("beat_last", 192'(dout_last), 192'(beats == ROWS - 1));
                if (lane_check && beats == 0) begin
                    row_v = dout;
`ifdef NTT_UNLOAD_REDUCE_EN
                    check_eq("lane_3328", 192'(row_v[11:0]), 192'(3328));
                    check_eq("lane_3329", 192'(row_v[23:12]), 192'(0));
                    check_eq("lane_4000", 192'(row_v[35:24]), 192'(671));
`else
                    check_eq("lane_3328", 192'(row_v[11:0]), 192'(3328));
                    check_eq("lane_3329", 192'(row_v[23:12]), 192'(3329));
                    check_eq("lane_4000", 192'(row_v[35:24]), 192'(4000));
`endif
                end
                if (beats == ROWS - 1) last_cyc = cyc;
                beats++;
            end
            if (mode == 4 && beats == 12) begin
                rst_i = 1'b1;
                start_unload = 1'b0;
                @(negedge clk);
                check_idle_outputs("abort");
                rst_i = 1'b0;
                @(negedge clk);
                return;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            if (cyc >= 400) begin
                check_eq("timeout", 192'(0), 192'(1));
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start_unload = 1'b0;
        check_eq("beat_count", 192'(beats), 192'(ROWS));
        check_eq("read_count", 192'(reads), 192'(ROWS));
        check_eq("done_count", 192'(done_cnt), 192'(1));
        check_eq("first_valid", 192'(first_valid), 192'(EXP_FIRST));
        check_eq("busy_end", 192'(busy), 192'(0));
    endtask

    initial begin
        clk = 1'b0;
        rst_i = 1'b1;
        start_unload = 1'b0;
        dout_ready = 1'b0;
        lane_check = 1'b0;
        n_checks = 0;
        n_errors = 0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            mem[r] = '0;
            for (int j = 0; j < 16; j++) mem[r][j*12 +: 12] = 12'(16 * r + j);
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk);

        run_unload(0);
        run_unload(1);
        run_unload(2);
        run_unload(3);
        run_unload(4);
        run_unload(0);

        mem[0][11:0]  = 12'd3328;
        mem[0][23:12] = 12'd3329;
        mem[0][35:24] = 12'd4000;
        lane_check = 1'b1;
        run_unload(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
